// File: rtl/chess_timer_core.sv
// Multi-player chess-clock timing core.
// One BCD mm:ss countdown per player; the active player counts down on each CE tick.
// MOVE adds a Fischer increment to the active player and passes the turn round-robin.
// A player that reaches 00:00 latches its flag bit and freezes the core until reload or reset.
module chess_timer_core #(
  parameter int unsigned PLAYERS     = 2,
  parameter int unsigned ACT_W       = 1,
  parameter logic [7:0]  DEFAULT_MIN = 8'h05,
  parameter int unsigned INC_SEC     = 0
) (
  input  logic                   CLK,
  input  logic                   CLR,
  input  logic                   CE,
  input  logic                   MOVE,
  input  logic                   STOP,
  input  logic                   Set_Impulse,
  input  logic [7:0]             SET_MIN,
  input  logic [7:0]             SET_SEC,
  output logic [ACT_W-1:0]       active,
  output logic                   running,
  output logic [PLAYERS-1:0]     flag,
  output logic [16*PLAYERS-1:0]  time_bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StFlag} state_e;

  state_e                 state_q, state_d;
  logic [15:0]            time_q [PLAYERS];
  logic [15:0]            time_d [PLAYERS];
  logic [ACT_W-1:0]       active_q, active_d;
  logic [PLAYERS-1:0]     flag_q, flag_d;
  logic                   running_q, running_d;

  logic                   preset_valid;
  logic                   load_ok;
  logic [15:0]            cur_time;
  logic [15:0]            dec_time;
  logic [15:0]            inc_time;
  logic                   hit_zero;
  logic [ACT_W-1:0]       next_act;

  // One-second BCD countdown; 00:00 is held so a stray tick cannot wrap to 99:59.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (t != 16'h0000) begin
      if (su != 4'd0) begin
        su = su - 4'd1;
      end else begin
        su = 4'd9;
        if (st != 4'd0) begin
          st = st - 4'd1;
        end else begin
          st = 4'd5;
          if (mu != 4'd0) begin
            mu = mu - 4'd1;
          end else begin
            mu = 4'd9;
            mt = mt - 4'd1;
          end
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  // Add the Fischer increment to seconds, carry into BCD minutes, saturate at 99:59.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    logic [6:0] s;
    logic       carry;
    {mt, mu, st, su} = t;
    s     = ({3'b000, st} * 7'd10) + {3'b000, su} + 7'(INC_SEC);
    carry = 1'b0;
    if (s >= 7'd60) begin
      s     = s - 7'd60;
      carry = 1'b1;
    end
    if (carry) begin
      if ({mt, mu} == 8'h99) begin
        return 16'h9959;
      end
      if (mu == 4'd9) begin
        mu = 4'd0;
        mt = mt + 4'd1;
      end else begin
        mu = mu + 4'd1;
      end
    end
    st = 4'(s / 7'd10);
    su = 4'(s % 7'd10);
    return {mt, mu, st, su};
  endfunction

  // A preset is usable only if every digit is decimal, seconds <= 59 and it is not 00:00.
  always_comb begin
    preset_valid = (SET_MIN[7:4] <= 4'd9) && (SET_MIN[3:0] <= 4'd9) &&
                   (SET_SEC[7:4] <= 4'd5) && (SET_SEC[3:0] <= 4'd9) &&
                   ({SET_MIN, SET_SEC} != 16'h0000);
    load_ok      = Set_Impulse && preset_valid && (state_q != StRun);
  end

  // Active player's time and its decremented/incremented versions.
  always_comb begin
    cur_time = 16'h0000;
    for (int i = 0; i < int'(PLAYERS); i++) begin
      if (ACT_W'(i) == active_q) begin
        cur_time = time_q[i];
      end
    end
    dec_time = CE ? bcd_dec(cur_time) : cur_time;
    hit_zero = CE && (dec_time == 16'h0000);
    inc_time = MOVE ? bcd_inc(dec_time) : dec_time;
    next_act = (active_q == ACT_W'(PLAYERS - 1)) ? '0 : active_q + ACT_W'(1);
  end

  // Next-state logic for the turn FSM and the per-player clocks.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    flag_d   = flag_q;
    time_d   = time_q;

    unique case (state_q)
      StIdle: begin
        if (load_ok) begin
          state_d = StIdle;
        end else if (MOVE && !STOP) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (STOP) begin
          state_d = StPause;
        end else if (hit_zero) begin
          // Flag wins over a same-edge MOVE: no increment, turn stays put.
          state_d = StFlag;
          for (int i = 0; i < int'(PLAYERS); i++) begin
            if (ACT_W'(i) == active_q) begin
              time_d[i] = dec_time;
              flag_d[i] = 1'b1;
            end
          end
        end else begin
          for (int i = 0; i < int'(PLAYERS); i++) begin
            if (ACT_W'(i) == active_q) begin
              time_d[i] = inc_time;
            end
          end
          if (MOVE) begin
            active_d = next_act;
          end
        end
      end
      StPause: begin
        if (!load_ok && !STOP) begin
          state_d = StRun;
        end
      end
      StFlag: begin
        state_d = StFlag;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Preset load overrides any other transition out of IDLE/PAUSE/FLAG.
    if (load_ok) begin
      state_d  = StIdle;
      active_d = '0;
      flag_d   = '0;
      for (int i = 0; i < int'(PLAYERS); i++) begin
        time_d[i] = {SET_MIN, SET_SEC};
      end
    end

    running_d = (state_d == StRun);
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q   <= StIdle;
      active_q  <= '0;
      flag_q    <= '0;
      running_q <= 1'b0;
      for (int i = 0; i < int'(PLAYERS); i++) begin
        time_q[i] <= {DEFAULT_MIN, 8'h00};
      end
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      flag_q    <= flag_d;
      running_q <= running_d;
      for (int i = 0; i < int'(PLAYERS); i++) begin
        time_q[i] <= time_d[i];
      end
    end
  end

  for (genvar g = 0; g < int'(PLAYERS); g++) begin : g_bus
    assign time_bus[16*g +: 16] = time_q[g];
  end

  assign active  = active_q;
  assign running = running_q;
  assign flag    = flag_q;

endmodule
